// File: rtl/paillier_modexp_scheduler.sv
// Command sequencer for one Paillier modular exponentiation (r^n mod n^2) on the shared
// Montgomery datapath: block-serial exponent load, then left-to-right square-and-multiply.
module paillier_modexp_scheduler #(
    parameter int REGISTER_SIZE  = 32,
    parameter int EXP_BITS       = 2048,
    parameter int NUM_EXP_BLOCKS = EXP_BITS / REGISTER_SIZE
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [REGISTER_SIZE-1:0]    exp_block_in,
    input  logic                        exp_valid_in,
    output logic                        exp_ready_out,
    output logic                        op_valid_out,
    output logic [2:0]                  op_code_out,
    input  logic                        op_ready_in,
    input  logic                        op_done_in,
    output logic [$clog2(EXP_BITS)-1:0] bit_index_out,
    output logic                        busy_out,
    output logic                        done_out
);
    localparam int BIT_W = $clog2(EXP_BITS);
    localparam int CNT_W = (NUM_EXP_BLOCKS > 1) ? $clog2(NUM_EXP_BLOCKS) : 1;

    localparam logic [2:0] OP_TO_MONT_BASE = 3'd0;
    localparam logic [2:0] OP_LOAD_ONE     = 3'd1;
    localparam logic [2:0] OP_SQUARE       = 3'd2;
    localparam logic [2:0] OP_MULTIPLY     = 3'd3;
    localparam logic [2:0] OP_FROM_MONT    = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_EXP, S_TO_MONT, S_INIT_ACC, S_SQUARE,
        S_MULTIPLY, S_NEXT_BIT, S_FROM_MONT, S_FINISH
    } state_t;

    state_t             state_reg, state_next;
    logic               wait_reg, wait_next;
    logic [CNT_W-1:0]   blk_cnt_reg, blk_cnt_next;
    logic [BIT_W-1:0]   bit_idx_reg, bit_idx_next;
    logic               op_valid_reg, op_valid_next;
    logic [2:0]         op_code_reg, op_code_next;
    logic               exp_ready_reg, exp_ready_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               blk_we;
    logic               cmd_done;

    logic [REGISTER_SIZE-1:0] exp_blk_reg [NUM_EXP_BLOCKS];
    logic [EXP_BITS-1:0]      exp_bits;

    function automatic logic is_cmd_state(input state_t s);
        return (s == S_TO_MONT) || (s == S_INIT_ACC) || (s == S_SQUARE) ||
               (s == S_MULTIPLY) || (s == S_FROM_MONT);
    endfunction

    function automatic logic [2:0] code_of(input state_t s);
        case (s)
            S_TO_MONT:   return OP_TO_MONT_BASE;
            S_INIT_ACC:  return OP_LOAD_ONE;
            S_SQUARE:    return OP_SQUARE;
            S_MULTIPLY:  return OP_MULTIPLY;
            S_FROM_MONT: return OP_FROM_MONT;
            default:     return 3'd0;
        endcase
    endfunction

    // One register per exponent block, written when the block counter selects it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_EXP_BLOCKS; gi++) begin : g_exp_blk
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in)
                    exp_blk_reg[gi] <= '0;
                else if (blk_we && blk_cnt_reg == CNT_W'(gi))
                    exp_blk_reg[gi] <= exp_block_in;
            end
            assign exp_bits[gi*REGISTER_SIZE +: REGISTER_SIZE] = exp_blk_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= S_IDLE;
            wait_reg      <= 1'b0;
            blk_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            op_valid_reg  <= 1'b0;
            op_code_reg   <= 3'd0;
            exp_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            blk_cnt_reg   <= blk_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            op_valid_reg  <= op_valid_next;
            op_code_reg   <= op_code_next;
            exp_ready_reg <= exp_ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        blk_cnt_next = blk_cnt_reg;
        bit_idx_next = bit_idx_reg;
        blk_we       = 1'b0;
        cmd_done     = 1'b0;

        // ISSUE until accepted, then WAIT; done is only honoured in WAIT.
        if (is_cmd_state(state_reg)) begin
            if (!wait_reg) begin
                if (op_ready_in)
                    wait_next = 1'b1;
            end else if (op_done_in) begin
                wait_next = 1'b0;
                cmd_done  = 1'b1;
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (start_in) begin
                    state_next   = S_LOAD_EXP;
                    blk_cnt_next = '0;
                end
            end
            S_LOAD_EXP: begin
                if (exp_valid_in && exp_ready_reg) begin
                    blk_we = 1'b1;
                    if (blk_cnt_reg == CNT_W'(NUM_EXP_BLOCKS - 1)) begin
                        blk_cnt_next = '0;
                        state_next   = S_TO_MONT;
                    end else begin
                        blk_cnt_next = blk_cnt_reg + 1'b1;
                    end
                end
            end
            S_TO_MONT:   if (cmd_done) state_next = S_INIT_ACC;
            S_INIT_ACC: begin
                if (cmd_done) begin
                    state_next   = S_SQUARE;
                    bit_idx_next = BIT_W'(EXP_BITS - 1);
                end
            end
            S_SQUARE: begin
                if (cmd_done)
                    state_next = exp_bits[bit_idx_reg] ? S_MULTIPLY : S_NEXT_BIT;
            end
            S_MULTIPLY:  if (cmd_done) state_next = S_NEXT_BIT;
            S_NEXT_BIT: begin
                if (bit_idx_reg == '0) begin
                    state_next = S_FROM_MONT;
                end else begin
                    bit_idx_next = bit_idx_reg - 1'b1;
                    state_next   = S_SQUARE;
                end
            end
            S_FROM_MONT: if (cmd_done) state_next = S_FINISH;
            S_FINISH:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase

        // Outputs are registered from the next state so each drives straight from a flop.
        op_valid_next  = is_cmd_state(state_next) && !wait_next;
        op_code_next   = code_of(state_next);
        exp_ready_next = (state_next == S_LOAD_EXP);
        busy_next      = (state_next != S_IDLE) && (state_next != S_FINISH);
        done_next      = (state_next == S_FINISH);
    end

    assign exp_ready_out = exp_ready_reg;
    assign op_valid_out  = op_valid_reg;
    assign op_code_out   = op_code_reg;
    assign bit_index_out = bit_idx_reg;
    assign busy_out      = busy_reg;
    assign done_out      = done_reg;

endmodule

// File: tb/tb_paillier_modexp_scheduler.sv
// Directed bench for paillier_modexp_scheduler with a 64-bit exponent and a behavioural
// datapath (accept after 2 cycles, done 5 cycles after accept).
module tb_paillier_modexp_scheduler;
    localparam int RS = 32;
    localparam int EB = 64;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [RS-1:0] exp_block_in;
    logic          exp_valid_in;
    logic          exp_ready_out;
    logic          op_valid_out;
    logic [2:0]    op_code_out;
    logic          op_ready_in;
    logic          op_done_in;
    logic [5:0]    bit_index_out;
    logic          busy_out;
    logic          done_out;

    paillier_modexp_scheduler #(.REGISTER_SIZE(RS), .EXP_BITS(EB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .exp_block_in(exp_block_in), .exp_valid_in(exp_valid_in), .exp_ready_out(exp_ready_out),
        .op_valid_out(op_valid_out), .op_code_out(op_code_out), .op_ready_in(op_ready_in),
        .op_done_in(op_done_in), .bit_index_out(bit_index_out), .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int log_q[$];
    int exp_q[$];
    int m_phase = 0;
    int m_cnt   = 0;
    bit hold_ready = 1'b0;
    bit spur_en    = 1'b0;
    int done_cnt   = 0;
    logic busy_at_done = 1'b0;

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    // Datapath model; logs code*100 + bit_index for every accepted command.
    initial begin
        op_ready_in = 1'b0;
        op_done_in  = 1'b0;
        forever begin
            @(negedge clk_in);
            op_ready_in = 1'b0;
            op_done_in  = 1'b0;
            if (!rst_in) begin
                m_phase = 0;
                m_cnt   = 0;
            end else if (m_phase == 0) begin
                if (op_valid_out) begin
                    m_cnt++;
                    if (spur_en && m_cnt == 1) op_done_in = 1'b1;
                    if (m_cnt >= 2 && !hold_ready) begin
                        op_ready_in = 1'b1;
                        m_phase = 1;
                        m_cnt   = 0;
                        log_q.push_back(int'(op_code_out) * 100 + int'(bit_index_out));
                    end
                end
            end else begin
                m_cnt++;
                if (m_cnt == 5) begin
                    op_done_in = 1'b1;
                    m_phase = 0;
                    m_cnt   = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (done_out) begin
                done_cnt++;
                busy_at_done = busy_out;
            end
        end
    end

    task automatic build_expected(input logic [63:0] e);
        exp_q.delete();
        exp_q.push_back(0);
        exp_q.push_back(100);
        for (int b = EB - 1; b >= 0; b--) begin
            exp_q.push_back(200 + b);
            if (e[b]) exp_q.push_back(300 + b);
        end
        exp_q.push_back(400);
    endtask

    task automatic load_exp(input string name, input logic [63:0] e, input bit gaps);
        for (int k = 0; k < 2; k++) begin
            int t;
            if (gaps) begin
                exp_valid_in = 1'b0;
                exp_block_in = 32'hDEAD_BEEF;
                @(negedge clk_in);
            end
            exp_block_in = e[k*RS +: RS];
            exp_valid_in = 1'b1;
            t = 0;
            while (!exp_ready_out && t < 100) begin
                @(negedge clk_in);
                t++;
            end
            @(negedge clk_in);
        end
        check_value({name, "_ready_low"}, 64'(exp_ready_out), 64'd0);
        if (gaps) begin
            exp_block_in = 32'h1234_5678;
            repeat (2) @(negedge clk_in);
        end
        exp_valid_in = 1'b0;
        check_value({name, "_exp_reg"}, dut.exp_bits, e);
    endtask

    task automatic begin_run(input string name, input logic [63:0] e, input bit gaps, input bit keep_start);
        log_q.delete();
        done_cnt = 0;
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        if (!keep_start) start_in = 1'b0;
        check_value({name, "_busy_start"}, 64'(busy_out), 64'd1);
        load_exp(name, e, gaps);
    endtask

    task automatic end_run(input string name, input logic [63:0] e);
        int t;
        t = 0;
        while (!done_out && t < 5000) begin
            @(negedge clk_in);
            t++;
        end
        check_value({name, "_done_seen"}, 64'(done_out), 64'd1);
        start_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_value({name, "_done_count"}, 64'(done_cnt), 64'd1);
        check_value({name, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        check_value({name, "_idle_after"}, 64'(busy_out), 64'd0);
        build_expected(e);
        check_value({name, "_cmd_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check_value($sformatf("%s_cmd%0d", name, i),
                        64'(i < log_q.size() ? log_q[i] : -1), 64'(exp_q[i]));
        $display("[TB] %s: exp=0x%016h commands=%0d", name, e, log_q.size());
    endtask

    task automatic check_outputs_zero(input string name);
        check_value({name, "_op_valid"}, 64'(op_valid_out), 64'd0);
        check_value({name, "_op_code"}, 64'(op_code_out), 64'd0);
        check_value({name, "_busy"}, 64'(busy_out), 64'd0);
        check_value({name, "_done"}, 64'(done_out), 64'd0);
        check_value({name, "_exp_ready"}, 64'(exp_ready_out), 64'd0);
        check_value({name, "_bit_index"}, 64'(bit_index_out), 64'd0);
    endtask

    initial begin
        int sq;
        int t;
        rst_in       = 1'b0;
        start_in     = 1'b0;
        exp_block_in = '0;
        exp_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset");
        rst_in = 1'b1;

        // 1: exponent 5
        begin_run("exp5", 64'h5, 1'b0, 1'b0);
        end_run("exp5", 64'h5);

        // 2: zero and all-ones exponents
        begin_run("exp0", 64'h0, 1'b0, 1'b0);
        end_run("exp0", 64'h0);
        begin_run("exp_ones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        end_run("exp_ones", 64'hFFFF_FFFF_FFFF_FFFF);

        // 3: gapped load, block order visible through MULTIPLY placement
        begin_run("gaps", 64'h8000_0000_0000_0001, 1'b1, 1'b0);
        end_run("gaps", 64'h8000_0000_0000_0001);

        // 4: start held high and spurious done during ISSUE
        spur_en = 1'b1;
        begin_run("start_held", 64'h5, 1'b0, 1'b1);
        end_run("start_held", 64'h5);
        spur_en = 1'b0;

        // 5: reset during WAIT of the 10th SQUARE, then a fresh run
        begin_run("mid_reset", 64'h5, 1'b0, 1'b0);
        t = 0;
        sq = 0;
        while (t < 3000) begin
            @(negedge clk_in);
            t++;
            sq = 0;
            foreach (log_q[i]) if (log_q[i] / 100 == 2) sq++;
            if (sq == 10 && m_phase == 1 && m_cnt >= 1) break;
        end
        check_value("mid_reset_reached", 64'(sq), 64'd10);
        rst_in = 1'b0;
        #1;
        check_outputs_zero("mid_reset_async");
        @(negedge clk_in);
        check_outputs_zero("mid_reset_edge");
        @(negedge clk_in);
        rst_in = 1'b1;
        begin_run("after_reset", 64'h5, 1'b0, 1'b0);
        end_run("after_reset", 64'h5);

        // 6: datapath stalls ready for 50 cycles on the first command
        hold_ready = 1'b1;
        begin_run("stall", 64'h5, 1'b0, 1'b0);
        t = 0;
        while (!op_valid_out && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        for (int c = 0; c < 50; c++) begin
            check_value($sformatf("stall_valid_c%0d", c), 64'(op_valid_out), 64'd1);
            check_value($sformatf("stall_code_c%0d", c), 64'(op_code_out), 64'd0);
            check_value($sformatf("stall_busy_c%0d", c), 64'(busy_out), 64'd1);
            @(negedge clk_in);
        end
        hold_ready = 1'b0;
        end_run("stall", 64'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
